// File: rtl/mac_pkg.sv
// Shared definitions for the 4-lane MAC stream controller: lane count,
// default widths and the controller state encoding.
package mac_pkg;

    localparam int unsigned LANES           = 4;
    localparam int unsigned BW_DEFAULT      = 4;
    localparam int unsigned PSUM_BW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mac_dot4.sv
// Combinational 4-lane dot product of unsigned activations and signed weights,
// wrapped to psum_bw bits.
module mac_dot4
    import mac_pkg::*;
#(
    parameter int unsigned bw      = BW_DEFAULT,
    parameter int unsigned psum_bw = PSUM_BW_DEFAULT
) (
    input  logic [LANES*bw-1:0] x,
    input  logic [LANES*bw-1:0] w,
    output logic [psum_bw-1:0]  mac
);

    logic signed [bw:0]        xs;
    logic signed [bw-1:0]      ws;
    logic signed [psum_bw-1:0] prod;
    logic signed [psum_bw-1:0] sum;

    // Activations get a zero sign bit so the product is a plain signed multiply.
    always_comb begin
        xs   = '0;
        ws   = '0;
        prod = '0;
        sum  = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            xs   = signed'({1'b0, x[k*bw +: bw]});
            ws   = signed'(w[k*bw +: bw]);
            prod = psum_bw'(xs) * psum_bw'(ws);
            sum  = sum + prod;
        end
        mac = sum;
    end

endmodule

// File: rtl/mac_stream_ctrl.sv
// Producer-side MAC controller: accumulates len dot-product groups from a
// valid/ready stream and presents the final psum on a valid/ready output.
module mac_stream_ctrl
    import mac_pkg::*;
#(
    parameter int unsigned bw      = BW_DEFAULT,
    parameter int unsigned psum_bw = PSUM_BW_DEFAULT,
    parameter int unsigned len     = 5,
    parameter int unsigned cnt_bw  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*bw-1:0] x_in,
    input  logic [LANES*bw-1:0] w_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [psum_bw-1:0]  out_data,
    output logic                busy
);

    state_t               state_q, state_d;
    logic [psum_bw-1:0]   acc_q, acc_d;
    logic [cnt_bw-1:0]    cnt_q, cnt_d;
    logic [psum_bw-1:0]   out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 in_ready_q, in_ready_d;
    logic [psum_bw-1:0]   mac;
    logic                 accept;

    mac_dot4 #(
        .bw      (bw),
        .psum_bw (psum_bw)
    ) u_dot4 (
        .x   (x_in),
        .w   (w_in),
        .mac (mac)
    );

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = mac;
                    cnt_d   = cnt_bw'(1);
                    state_d = (len == 1) ? DONE : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d = acc_q + mac;
                    if (cnt_q == cnt_bw'(len - 1)) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + cnt_bw'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Result register only loads on entry to DONE so it holds between results.
        if (state_d == DONE && state_q != DONE) begin
            out_data_d = acc_d;
        end
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        in_ready_d  = (state_d != DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mac_stream_ctrl.sv
// Bench for mac_stream_ctrl: a 16-bit and a 10-bit instance share stimulus and
// are checked every cycle against a group-counting model plus literal results.
module tb_mac_stream_ctrl;

    localparam int LEN = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] x_in, w_in;
    logic        out_ready;
    logic        in_ready, out_valid, busy;
    logic [15:0] out_data;
    logic        in_ready10, out_valid10, busy10;
    logic [9:0]  out_data10;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic cmp_en = 1'b0;

    mac_stream_ctrl #(.bw(4), .psum_bw(16), .len(5), .cnt_bw(3)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .w_in(w_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    mac_stream_ctrl #(.bw(4), .psum_bw(10), .len(5), .cnt_bw(3)) u_dut10 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready10),
        .x_in(x_in), .w_in(w_in), .out_valid(out_valid10), .out_ready(out_ready),
        .out_data(out_data10), .busy(busy10)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Plain integer dot product: unsigned 4-bit X, two's-complement 4-bit W.
    function automatic int dot(input logic [15:0] x, input logic [15:0] w);
        int s;
        int xv;
        int wv;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            xv = int'(x[k*4 +: 4]);
            wv = int'(w[k*4 +: 4]);
            if (wv >= 8) wv = wv - 16;
            s = s + xv * wv;
        end
        return s;
    endfunction

    // Model: groups taken so far, running sum, last completed result, result pending.
    int   m_n;
    int   m_sum;
    int   m_res;
    logic m_pend;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_n    <= 0;
            m_sum  <= 0;
            m_res  <= 0;
            m_pend <= 1'b0;
        end else if (m_pend) begin
            if (out_ready) m_pend <= 1'b0;
        end else if (in_valid) begin
            if (m_n == LEN - 1) begin
                m_res  <= m_sum + dot(x_in, w_in);
                m_sum  <= 0;
                m_n    <= 0;
                m_pend <= 1'b1;
            end else begin
                m_sum <= m_sum + dot(x_in, w_in);
                m_n   <= m_n + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("in_ready",    32'(in_ready),    32'(!m_pend));
            chk("out_valid",   32'(out_valid),   32'(m_pend));
            chk("busy",        32'(busy),        32'(m_pend || (m_n != 0)));
            chk("out_data",    32'(out_data),    32'(m_res[15:0]));
            chk("in_ready10",  32'(in_ready10),  32'(!m_pend));
            chk("out_valid10", 32'(out_valid10), 32'(m_pend));
            chk("busy10",      32'(busy10),      32'(m_pend || (m_n != 0)));
            chk("out_data10",  32'(out_data10),  32'(m_res[9:0]));
        end
    end

    int          pulse_cyc[$];
    logic [15:0] pulse_dat[$];
    logic        prev_ov = 1'b0;

    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            pulse_cyc.push_back(cyc);
            pulse_dat.push_back(out_data);
        end
        prev_ov <= out_valid;
    end

    task automatic send(input logic [15:0] x, input logic [15:0] w);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = x;
        w_in     = w;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            x_in     = 16'($urandom);
            w_in     = 16'($urandom);
        end
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL out_timeout actual=out_valid_low required=out_valid_high");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        x_in      = '0;
        w_in      = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        #2 reset = 1'b0;
        cmp_en = 1'b1;

        // Unit ones: 4 per group, 20 total.
        for (int i = 0; i < 5; i++) send(16'h1111, 16'h1111);
        idle(1);
        wait_out();
        chk("ones_data",     32'(out_data), 32'h0014);
        chk("ones_in_ready", 32'(in_ready), 32'd0);
        idle(2);

        // Negative extremes: 15 * -8 * 4 = -480 per group.
        for (int i = 0; i < 5; i++) send(16'hFFFF, 16'h8888);
        idle(1);
        wait_out();
        chk("neg_data", 32'(out_data), 32'hF6A0);
        idle(2);

        // Wrap: 420 per group, 2100 total; the 10-bit instance wraps to 0x034.
        for (int i = 0; i < 5; i++) send(16'hFFFF, 16'h7777);
        idle(1);
        wait_out();
        chk("wrap_data16", 32'(out_data),   32'h0834);
        chk("wrap_data10", 32'(out_data10), 32'h0034);
        idle(2);

        // Bubbles between groups give the same result as the gapless run.
        for (int i = 0; i < 5; i++) begin
            send(16'h1111, 16'h1111);
            if (i < 4) idle(2);
        end
        idle(1);
        wait_out();
        chk("bubble_data", 32'(out_data), 32'h0014);
        idle(2);

        // Output backpressure while a new group is being offered.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(16'h2222, 16'h1111);
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = 16'h1111;
        w_in     = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid",    32'(out_valid), 32'd1);
            chk("hold_data",     32'(out_data),  32'h0028);
            chk("hold_in_ready", 32'(in_ready),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(16'h1111, 16'h1111);
        idle(1);
        wait_out();
        chk("after_hold_data", 32'(out_data), 32'h0014);
        idle(2);

        // Asynchronous reset mid-accumulation.
        send(16'h3333, 16'h7777);
        send(16'h3333, 16'h7777);
        idle(1);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy",      32'(busy),      32'd0);
        chk("arst_out_data",  32'(out_data),  32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 5; i++) send(16'h2222, 16'hFFFF);
        idle(1);
        wait_out();
        chk("post_rst_data", 32'(out_data), 32'hFFD8);
        idle(3);

        // Back-to-back results with out_ready held high.
        pulse_cyc.delete();
        pulse_dat.delete();
        for (int i = 0; i < 5; i++) send(16'h3333, 16'h1111);
        for (int i = 0; i < 5; i++) send(16'h1111, 16'h1111);
        idle(8);
        chk("b2b_pulses", 32'(pulse_cyc.size()), 32'd2);
        if (pulse_cyc.size() == 2) begin
            chk("b2b_first",  32'(pulse_dat[0]), 32'h003C);
            chk("b2b_second", 32'(pulse_dat[1]), 32'h0014);
            chk("b2b_gap",    32'(pulse_cyc[1] - pulse_cyc[0]), 32'(LEN + 1));
        end

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_stream_ctrl.md
Name: mac_stream_ctrl

Overview:
- Producer-side controller for the 4-lane MAC datapath: the sender that drives groups of four unsigned activations and four signed weights into the MAC.
- Accepts groups over a valid/ready input stream and computes the 4-lane dot product each cycle.
- Feeds the partial sum back into an internal accumulator. After LEN groups it presents the final psum on a valid/ready output.
- Sits between the activation/weight SRAM readers and the output psum buffer.

Parameters:
- bw, 4, activation/weight lane width
- psum_bw, 16, accumulator and output width
- len, 5, groups accumulated per output result
- cnt_bw, 3, counter width; must satisfy 2^cnt_bw >= len

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  group {x_in, w_in} is valid
- in_ready  output  1  controller accepts a group this cycle
- x_in  input  4*bw  activations X3..X0; lane k = bits [k*bw +: bw], unsigned
- w_in  input  4*bw  weights W3..W0; same packing, two's complement
- out_valid  output  1  out_data holds a completed result
- out_ready  input  1  downstream takes the result
- out_data  output  psum_bw  accumulated result
- busy  output  1  high in ACC or DONE

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE, acc = 0, cnt = 0
  - out_valid = 0, out_data = 0, busy = 0, in_ready = 1
- Accept event: in_valid && in_ready at a rising edge.
- Group product: mac = sum over k of (zero-extend X_k to bw+1 signed) * (signed W_k).
  - mac is sign-extended to psum_bw.
  - All additions wrap modulo 2^psum_bw; no saturation.
- FSM states: IDLE, ACC, DONE.
- IDLE (in_ready = 1):
  - On accept: acc <= mac (prior acc discarded); cnt <= 1.
  - If len == 1, go to DONE; else go to ACC.
- ACC (in_ready = 1):
  - On accept: acc <= acc + mac; cnt <= cnt + 1.
  - If cnt == len-1, go to DONE and cnt <= 0.
  - No accept: hold state, acc and cnt (bubbles allowed anywhere).
- DONE (in_ready = 0):
  - out_valid = 1, out_data = acc; both stay stable until handshake.
  - On out_ready: go to IDLE; out_valid drops the next cycle. acc is kept; the next IDLE accept overwrites it.
  - No new group is accepted in the cycle the result drains. Throughput is len+1 cycles per result at full rate.
- Latency: the last group is accepted at edge N; out_valid is high after edge N (registered), i.e. the cycle after the final accept.
- out_data is a registered copy of acc. It is 0 after reset and keeps the last result while out_valid = 0.
- in_ready is decoded from state only; it never depends on in_valid combinationally.
- out_ready while out_valid = 0 is ignored.
- x_in/w_in values while in_valid = 0 have no effect.
- Reset mid-accumulation discards partial acc and cnt; the next accept starts a fresh result.

Decomposition:
- Shared package mac_pkg holds:
  - lane count (4)
  - FSM state encoding (IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2)
  - default bw/psum_bw
- One combinational sub-module, mac_dot4: 4-lane unsigned×signed dot product, output psum_bw wide.
- The controller instantiates mac_dot4 and owns the FSM, counter, accumulator and output register.

Test Plan:
- Unit ones: 5 back-to-back groups, all X=1, W=1 -> one out_valid pulse with out_data = 0x0014; in_ready low exactly during DONE.
- Negative extremes: 5 groups, X=15, W=-8 (-480 per group) -> out_data = 0xF6A0 (-2400); checks zero-extension of X and sign-extension of W.
- Wrap: psum_bw=10, 5 groups X=15, W=7 (420 per group, 2100 total) -> out_data = 10'h034; no saturation.
- Backpressure and bubbles:
  - in_valid toggles 1,0,0,1,... over 5 groups; result equals the gapless run.
  - out_ready held low 3 cycles in DONE: out_valid and out_data stable, in_ready = 0, offered groups not consumed.
- Reset mid-operation: accept 2 groups, assert reset asynchronously between edges.
  - Immediately: out_valid = 0, busy = 0, out_data = 0.
  - 5 fresh groups of X=2, W=-1 -> out_data = 0xFFD8 (-40).
- Back-to-back results: two 5-group runs with out_ready tied high.
  - Second result does not include the first (acc overwritten on the IDLE accept).
  - Exactly len+1 cycles between out_valid pulses.
